iorq_bus_fsm: RTL and testbench
===============================

IORQ_BUS_FSM -- requirements
Module: iorq_bus_fsm

Interface
REQ-001 Parameter ADDR_W, default 8, width of sampled I/O address.
REQ-002 Parameter BASE, default 8'h40, first decoded port address.
REQ-003 Parameter NPORTS, default 4, number of consecutive decoded ports; legal 1..16; BASE+NPORTS SHALL be <= 2**ADDR_W.
REQ-004 Parameter QUAL_CYCLES, default 2, consecutive qualifying samples required before a tick; legal 1..7.
REQ-005 phi  input  1  system clock; all state SHALL update on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 iorq  input  1  I/O request, positive logic.
REQ-008 rd  input  1  read strobe, positive logic.
REQ-009 wr  input  1  write strobe, positive logic.
REQ-010 addr  input  ADDR_W  I/O address.
REQ-011 rd_tick  output  NPORTS  one-hot read tick, bit = port index.
REQ-012 wr_tick  output  NPORTS  one-hot write tick, bit = port index.
REQ-013 port  output  4  index (addr-BASE) of current/last qualified cycle.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 err  output  1  one-cycle pulse on sampled iorq&rd&wr.

Function
REQ-016 iorq, rd, wr, addr SHALL be registered on every phi rising edge; all decode uses only registered copies.
REQ-017 match SHALL be: s_iorq & (s_rd xor s_wr) & BASE <= s_addr <= BASE+NPORTS-1.
REQ-018 FSM states SHALL be IDLE, QUAL, FIRE, HOLD.
REQ-019 IDLE: on match latch index and direction; go FIRE if QUAL_CYCLES=1, else QUAL with count=1.
REQ-020 QUAL: match with same index and direction increments count; count reaching QUAL_CYCLES -> FIRE.
REQ-021 QUAL: any other sample -> HOLD if s_iorq high, else IDLE; no tick (aborted/short cycle).
REQ-022 FIRE: exactly one bit of rd_tick or wr_tick (per latched direction, latched index) SHALL be high for exactly one phi cycle; next state HOLD.
REQ-023 HOLD: remain until s_iorq low, then IDLE; no second tick within one iorq assertion.
REQ-024 Latency: inputs first sampled at edge k and held qualifying -> tick high from edge k+QUAL_CYCLES to edge k+QUAL_CYCLES+1.
REQ-025 Back-to-back: iorq low for one sample then a new qualifying cycle SHALL tick normally.
REQ-026 Address or direction change mid-cycle after FIRE SHALL be ignored until iorq low.
REQ-027 rd&wr together SHALL pulse err for each such sample and count as non-match.
REQ-028 Out-of-range address SHALL produce no tick, no err, and leave port unchanged.
REQ-029 All outputs SHALL be registered or decoded only from state registers (glitch-free).

Reset
REQ-030 reset low SHALL immediately force IDLE, count=0, all sample registers 0, rd_tick=0, wr_tick=0, port=0, busy=0, err=0.
REQ-031 reset asserted mid-cycle (QUAL/FIRE) SHALL suppress/truncate the tick; after release a still-asserted iorq SHALL requalify from IDLE.

Configuration
REQ-032 Macro IORQ_BUS_FSM_WR_EN: defined -> write cycles decoded per REQ-017..022.
REQ-033 Undefined -> wr input ignored (treated 0), wr_tick tied 0, err tied 0; match requires s_rd only.

Verification (ADDR_W=8, BASE=8'h40, NPORTS=4, QUAL_CYCLES=2, phi period 50 ns, WR_EN defined unless noted)
REQ-034 iorq=rd=1, addr=8'h42 held 4 cycles -> rd_tick=4'b0100 exactly one cycle, 2 edges after first sample; port=2; wr_tick=0.
REQ-035 iorq=wr=1, addr=8'h41 for 1 cycle only -> no tick, busy high 1 cycle then low; with 3 cycles -> wr_tick=4'b0010 once.
REQ-036 iorq=rd=1 at addr=8'h44 and 8'h3F -> no tick, no err, port unchanged.
REQ-037 iorq=rd=wr=1 at 8'h40 for 3 cycles -> err high 3 cycles, no ticks.
REQ-038 reset low while in FIRE -> rd_tick drops asynchronously; release with iorq/rd held at 8'h43 -> rd_tick=4'b1000 one cycle, 2 edges later.
REQ-039 WR_EN undefined: iorq=wr=1 at 8'h40, 4 cycles -> no tick, err=0; iorq=rd=1 -> normal read tick.

Source files
------------

// File: rtl/iorq_bus_fsm.sv
// I/O request decoder: samples the bus, qualifies a stable request and emits a
// one-cycle one-hot read/write tick. Write decode is enabled by IORQ_BUS_FSM_WR_EN.
module iorq_bus_fsm #(
  parameter int ADDR_W      = 8,
  parameter int BASE        = 'h40,
  parameter int NPORTS      = 4,
  parameter int QUAL_CYCLES = 2
) (
  input  logic              phi,
  input  logic              reset,
  input  logic              iorq,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  output logic [NPORTS-1:0] rd_tick,
  output logic [NPORTS-1:0] wr_tick,
  output logic [3:0]        port,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LO = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] HI = ADDR_W'(BASE + NPORTS - 1);
  localparam logic [2:0]        QC = 3'(QUAL_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_QUAL, ST_FIRE, ST_HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_iorq;
  logic                r_rd;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic [3:0]          r_idx;
  logic                r_dir;
  logic                w_latch;
  logic                w_wr_s;
  logic                w_in_rng;
  logic                w_match;
  logic                w_same;
  logic [3:0]          w_idx;
  logic [NPORTS-1:0]   w_onehot;

`ifdef IORQ_BUS_FSM_WR_EN
  logic r_wr;

  always_ff @(posedge phi or negedge reset) begin
    if (!reset) r_wr <= 1'b0;
    else        r_wr <= wr;
  end

  assign w_wr_s = r_wr;
`else
  // The strobe is read but forced low, so write cycles never decode.
  assign w_wr_s = wr & 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      r_iorq  <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_iorq  <= iorq;
      r_rd    <= rd;
      r_addr  <= addr;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_idx <= w_idx;
        r_dir <= w_wr_s;
      end
    end
  end

  assign w_in_rng = (r_addr >= LO) && (r_addr <= HI);
  assign w_idx    = 4'(r_addr - LO);
  assign w_match  = r_iorq && (r_rd ^ w_wr_s) && w_in_rng;
  assign w_same   = w_match && (w_idx == r_idx) && (w_wr_s == r_dir);

  // NOTE: every variable gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_match) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = 3'd1;
          w_state_nxt = (QC == 3'd1) ? ST_FIRE : ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (w_same) begin
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt + 3'd1 == QC) w_state_nxt = ST_FIRE;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_iorq ? ST_HOLD : ST_IDLE;
        end
      end
      ST_FIRE: begin
        // A request released right at the tick skips HOLD so a new cycle
        // one sample later is not swallowed.
        w_cnt_nxt   = '0;
        w_state_nxt = r_iorq ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!r_iorq) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_onehot = NPORTS'(1) << r_idx;
  assign port     = r_idx;
  assign busy     = (r_state != ST_IDLE);

  always_comb begin
    rd_tick = '0;
    wr_tick = '0;
    if (r_state == ST_FIRE) begin
      if (r_dir) wr_tick = w_onehot;
      else       rd_tick = w_onehot;
    end
  end

`ifdef IORQ_BUS_FSM_WR_EN
  assign err = r_iorq & r_rd & w_wr_s;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_iorq_bus_fsm.sv
// Scoreboard bench for iorq_bus_fsm: each driven cycle pushes the outputs
// expected after the sampling edge; they are popped and compared one cycle later.
module tb_iorq_bus_fsm;

  typedef struct {
    logic [3:0] rd_t;
    logic [3:0] wr_t;
    logic       busy;
    logic       err;
    logic [3:0] port;
  } exp_t;

  logic       phi = 1'b0;
  logic       reset = 1'b1;
  logic       iorq = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] addr = '0;
  logic [3:0] rd_tick;
  logic [3:0] wr_tick;
  logic [3:0] port;
  logic       busy;
  logic       err;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         row = 0;
  logic [3:0] lp;

  iorq_bus_fsm #(
    .ADDR_W(8), .BASE('h40), .NPORTS(4), .QUAL_CYCLES(2)
  ) dut (
    .phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .wr(wr), .addr(addr),
    .rd_tick(rd_tick), .wr_tick(wr_tick), .port(port), .busy(busy), .err(err)
  );

  always #25 phi = ~phi;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic compare_pending();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("row%0d rd_tick", row), 32'(rd_tick), 32'(e.rd_t));
      check($sformatf("row%0d wr_tick", row), 32'(wr_tick), 32'(e.wr_t));
      check($sformatf("row%0d busy", row), 32'(busy), 32'(e.busy));
      check($sformatf("row%0d err", row), 32'(err), 32'(e.err));
      check($sformatf("row%0d port", row), 32'(port), 32'(e.port));
    end
  endtask

  // Drive one sample and queue what the outputs must be after it is clocked in.
  task automatic cyc(input logic q, input logic r, input logic w, input logic [7:0] a,
                     input logic [3:0] e_rd, input logic [3:0] e_wr,
                     input logic e_busy, input logic e_err, input logic [3:0] e_port);
    @(negedge phi);
    compare_pending();
    row++;
    iorq = q;
    rd   = r;
    wr   = w;
    addr = a;
    sb.push_back('{rd_t: e_rd, wr_t: e_wr, busy: e_busy, err: e_err, port: e_port});
  endtask

  initial begin
    #10 reset = 1'b0;
    #10;
    check("reset rd_tick", 32'(rd_tick), 32'h0);
    check("reset wr_tick", 32'(wr_tick), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset port", 32'(port), 32'h0);
    @(negedge phi);
    @(negedge phi);
    reset = 1'b1;

    // Read at 0x42 held four samples.
    cyc(1, 1, 0, 8'h42, 4'b0000, 4'b0000, 0, 0, 4'd0);
    cyc(1, 1, 0, 8'h42, 4'b0000, 4'b0000, 1, 0, 4'd2);
    cyc(1, 1, 0, 8'h42, 4'b0100, 4'b0000, 1, 0, 4'd2);
    cyc(1, 1, 0, 8'h42, 4'b0000, 4'b0000, 1, 0, 4'd2);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'd2);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd2);

    // Back-to-back minimum-length reads separated by one idle sample.
    cyc(1, 1, 0, 8'h41, 4'b0000, 4'b0000, 0, 0, 4'd2);
    cyc(1, 1, 0, 8'h41, 4'b0000, 4'b0000, 1, 0, 4'd1);
    cyc(0, 0, 0, 8'h00, 4'b0010, 4'b0000, 1, 0, 4'd1);
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 0, 0, 4'd1);
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 1, 0, 4'd3);
    cyc(0, 0, 0, 8'h00, 4'b1000, 4'b0000, 1, 0, 4'd3);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd3);

    // Out-of-range addresses on both sides of the window.
    cyc(1, 1, 0, 8'h44, 4'b0000, 4'b0000, 0, 0, 4'd3);
    cyc(1, 1, 0, 8'h44, 4'b0000, 4'b0000, 0, 0, 4'd3);
    cyc(1, 1, 0, 8'h3f, 4'b0000, 4'b0000, 0, 0, 4'd3);
    cyc(1, 1, 0, 8'h3f, 4'b0000, 4'b0000, 0, 0, 4'd3);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd3);

    // Address and direction change after the tick are ignored.
    cyc(1, 1, 0, 8'h40, 4'b0000, 4'b0000, 0, 0, 4'd3);
    cyc(1, 1, 0, 8'h40, 4'b0000, 4'b0000, 1, 0, 4'd0);
    cyc(1, 1, 0, 8'h41, 4'b0001, 4'b0000, 1, 0, 4'd0);
    cyc(1, 1, 0, 8'h41, 4'b0000, 4'b0000, 1, 0, 4'd0);
    cyc(1, 0, 1, 8'h41, 4'b0000, 4'b0000, 1, 0, 4'd0);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'd0);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd0);

    // Address change during qualification aborts without a tick.
    cyc(1, 1, 0, 8'h42, 4'b0000, 4'b0000, 0, 0, 4'd0);
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 1, 0, 4'd2);
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 1, 0, 4'd2);
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 1, 0, 4'd2);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'd2);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd2);

`ifdef IORQ_BUS_FSM_WR_EN
    // Short write: one sample only.
    cyc(1, 0, 1, 8'h41, 4'b0000, 4'b0000, 0, 0, 4'd2);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'd1);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd1);
    // Write held three samples.
    cyc(1, 0, 1, 8'h41, 4'b0000, 4'b0000, 0, 0, 4'd1);
    cyc(1, 0, 1, 8'h41, 4'b0000, 4'b0000, 1, 0, 4'd1);
    cyc(1, 0, 1, 8'h41, 4'b0000, 4'b0010, 1, 0, 4'd1);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'd1);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd1);
    // Read and write together: error every sample, never a tick.
    cyc(1, 1, 1, 8'h40, 4'b0000, 4'b0000, 0, 1, 4'd1);
    cyc(1, 1, 1, 8'h40, 4'b0000, 4'b0000, 0, 1, 4'd1);
    cyc(1, 1, 1, 8'h40, 4'b0000, 4'b0000, 0, 1, 4'd1);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd1);
    lp = 4'd1;
`else
    // Write strobe ignored: no tick, no error.
    cyc(1, 0, 1, 8'h40, 4'b0000, 4'b0000, 0, 0, 4'd2);
    cyc(1, 0, 1, 8'h40, 4'b0000, 4'b0000, 0, 0, 4'd2);
    cyc(1, 0, 1, 8'h40, 4'b0000, 4'b0000, 0, 0, 4'd2);
    cyc(1, 0, 1, 8'h40, 4'b0000, 4'b0000, 0, 0, 4'd2);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd2);
    // With wr ignored, rd&wr is a plain read and err stays low.
    cyc(1, 1, 1, 8'h40, 4'b0000, 4'b0000, 0, 0, 4'd2);
    cyc(1, 1, 1, 8'h40, 4'b0000, 4'b0000, 1, 0, 4'd0);
    cyc(1, 1, 1, 8'h40, 4'b0001, 4'b0000, 1, 0, 4'd0);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'd0);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd0);
    lp = 4'd0;
`endif

    // Reset during FIRE truncates the tick; held request requalifies.
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 0, 0, lp);
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 1, 0, 4'd3);
    cyc(1, 1, 0, 8'h43, 4'b1000, 4'b0000, 1, 0, 4'd3);
    @(negedge phi);
    compare_pending();
    #5 reset = 1'b0;
    #1;
    check("rst_fire rd_tick", 32'(rd_tick), 32'h0);
    check("rst_fire busy", 32'(busy), 32'h0);
    check("rst_fire port", 32'(port), 32'h0);
    @(negedge phi);
    reset = 1'b1;
    cyc(1, 1, 0, 8'h43, 4'b0000, 4'b0000, 1, 0, 4'd3);
    cyc(1, 1, 0, 8'h43, 4'b1000, 4'b0000, 1, 0, 4'd3);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 1, 0, 4'd3);
    cyc(0, 0, 0, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'd3);
    @(negedge phi);
    compare_pending();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
